// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, idle line levels and clock polarity.
// Reused by the SPI master and by the flash/SPI bus bridges.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_e;

  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b1;
  localparam logic SPI_SS_IDLE   = 1'b1;  // level of each select line when idle

  // Counter width for a divider of 'div' cycles; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master: counts 0..CLK_DIV-1 and flags the
// last cycle of the current phase. restart_i forces the count back to 0.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam int CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = restart_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign phase_end_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: MSB-first shift of up to MAX_BITS bits with miso capture,
// one transfer in flight, sck derived from clock by a fixed half-period divider.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 64,
  parameter int SS_NUM   = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [$clog2(MAX_BITS+1)-1:0]    req_len,
  input  logic [MAX_BITS-1:0]              req_data,
  input  logic [SS_NUM-1:0]                req_ss,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [MAX_BITS-1:0]              rsp_data,
  output logic                             sck,
  output logic [SS_NUM-1:0]                ss,
  output logic                             mosi,
  input  logic                             miso,
  output spi_state_e                       dbg_state_o
);

  localparam int LEN_W = $clog2(MAX_BITS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);

  // Handshakes: a beat transfers on a posedge where valid && ready are both high.
  // req_ready is high only in IDLE; once rsp_valid rises it stays high with
  // rsp_data frozen until rsp_ready is seen.

  spi_state_e state_q, state_d;
  logic [LEN_W-1:0]    bits_q, bits_d;
  logic [MAX_BITS-1:0] tx_q, tx_d;
  logic [MAX_BITS-1:0] rx_q, rx_d;
  logic [SS_NUM-1:0]   ss_q, ss_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic             phase_end;
  logic             in_xfer;
  logic             accept;
  logic             rsp_fire;
  logic [LEN_W-1:0] len_sat;
  logic [LEN_W-1:0] shamt;

  assign in_xfer  = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                    (state_q == ST_LOW)   || (state_q == ST_HOLD);
  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign rsp_fire = rsp_valid_q && rsp_ready;
  assign len_sat  = (req_len > LEN_MAX) ? LEN_MAX : req_len;
  // Left-align the request so the first bit to send always sits in the MSB.
  assign shamt    = LEN_MAX - len_sat;

  spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i       (clock),
    .rst_i       (reset),
    .restart_i   (!in_xfer || phase_end),
    .phase_end_o (phase_end)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bits_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ss_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ss_q        <= ss_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = (len_sat == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP: if (phase_end) state_d = ST_HIGH;
      ST_HIGH:  if (phase_end) state_d = (bits_q == LEN_W'(1)) ? ST_HOLD : ST_LOW;
      ST_LOW:   if (phase_end) state_d = ST_HIGH;
      ST_HOLD:  if (phase_end) state_d = ST_DONE;
      ST_DONE:  if (rsp_fire)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ss_d        = ss_q;
    rsp_valid_d = (state_q == ST_DONE) && !rsp_fire;
    if (accept) begin
      bits_d = len_sat;
      tx_d   = req_data << shamt;
      rx_d   = '0;
      ss_d   = req_ss;
    end else if ((state_q == ST_HIGH) && phase_end) begin
      // miso is sampled on the last HIGH cycle, i.e. right at the sck fall.
      rx_d   = {rx_q[MAX_BITS-2:0], miso};
      bits_d = bits_q - LEN_W'(1);
      if (bits_q != LEN_W'(1)) tx_d = tx_q << 1;
    end
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    sck         = (state_q == ST_HIGH) ? ~SPI_CPOL : SPI_CPOL;
    ss          = in_xfer ? ~ss_q : {SS_NUM{SPI_SS_IDLE}};
    mosi        = ((state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW)) ?
                  tx_q[MAX_BITS-1] : SPI_MOSI_IDLE;
    rsp_valid   = rsp_valid_q;
    rsp_data    = rx_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=2 instance with a loopback/pattern slave and
// a CLK_DIV=1 instance in loopback, checked against a bit-level transfer model.
module tb_spi_master;
  import spi_pkg::*;

  localparam int MB = 64;
  localparam int LW = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic          a_sck, a_mosi, a_miso;
  logic [LW-1:0] a_req_len;
  logic [63:0]   a_req_data, a_rsp_data;
  logic [7:0]    a_req_ss, a_ss;
  spi_state_e    a_state;

  logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic          b_sck, b_mosi, b_miso;
  logic [LW-1:0] b_req_len;
  logic [63:0]   b_req_data, b_rsp_data;
  logic [7:0]    b_req_ss, b_ss;
  spi_state_e    b_state;

  int total = 0;
  int bad   = 0;

  spi_master #(.CLK_DIV(2), .MAX_BITS(64), .SS_NUM(8)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_len(a_req_len),
    .req_data(a_req_data), .req_ss(a_req_ss),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .sck(a_sck), .ss(a_ss), .mosi(a_mosi), .miso(a_miso), .dbg_state_o(a_state)
  );

  spi_master #(.CLK_DIV(1), .MAX_BITS(64), .SS_NUM(8)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_len(b_req_len),
    .req_data(b_req_data), .req_ss(b_req_ss),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .miso(b_miso), .dbg_state_o(b_state)
  );

  // Slave for instance A: loopback or a pattern shifted out MSB-first, advancing on sck fall.
  bit          lb_a;
  logic [63:0] slv_q;
  logic [7:0]  exp_ss_a;
  int          rises_a, hi_cnt_a, lo_cnt_a, tim_err_a, ss_err_a, ss_act_a;
  logic [63:0] mosi_cap_a;
  logic        sck_prev_a, mosi_rise_a;

  assign a_miso = lb_a ? a_mosi : slv_q[63];
  assign b_miso = b_mosi;

  always @(negedge clock) begin
    if (a_sck) begin
      if (!sck_prev_a) begin
        rises_a++;
        mosi_cap_a = {mosi_cap_a[62:0], a_mosi};
        if (rises_a > 1 && lo_cnt_a != 2) tim_err_a++;
        hi_cnt_a    = 0;
        mosi_rise_a = a_mosi;
      end
      hi_cnt_a++;
      if (a_mosi !== mosi_rise_a) tim_err_a++;
      if (a_ss !== exp_ss_a) ss_err_a++;
    end else begin
      if (sck_prev_a) begin
        if (hi_cnt_a != 2) tim_err_a++;
        lo_cnt_a = 0;
        slv_q    = slv_q << 1;
      end
      lo_cnt_a++;
    end
    if (a_ss !== 8'hFF) begin
      ss_act_a++;
      if (a_ss !== exp_ss_a) ss_err_a++;
    end
    sck_prev_a = a_sck;
  end

  int   rises_b, hi_cnt_b;
  logic sck_prev_b;
  always @(negedge clock) begin
    if (b_sck) begin
      if (!sck_prev_b) begin
        rises_b++;
        hi_cnt_b = 0;
      end
      hi_cnt_b++;
    end
    sck_prev_b = b_sck;
  end

  function automatic logic [63:0] mask_of(input int le);
    if (le >= 64) return '1;
    return (64'd1 << le) - 64'd1;
  endfunction

  // Cycles from the accept edge to the first rsp_valid sample.
  function automatic int exp_lat(input int le, input int h);
    return (le == 0) ? 1 : (2 * le + 1) * h + 1;
  endfunction

  task automatic clr_mon_a();
    rises_a = 0; hi_cnt_a = 0; lo_cnt_a = 0; tim_err_a = 0;
    ss_err_a = 0; ss_act_a = 0; mosi_cap_a = '0;
  endtask

  // Called at a negedge with instance A idle; returns just after the accept edge.
  task automatic start_a(input int len, input logic [63:0] data, input logic [7:0] ssel,
                         input bit lb, input logic [63:0] pat);
    int le;
    le = (len > MB) ? MB : len;
    clr_mon_a();
    lb_a     = lb;
    exp_ss_a = ~ssel;
    slv_q    = (le == 0) ? 64'd0 : pat << (MB - le);
    a_req_len   = LW'(len);
    a_req_data  = data;
    a_req_ss    = ssel;
    a_req_valid = 1'b1;
    @(posedge clock);
    #1 a_req_valid = 1'b0;
  endtask

  task automatic wait_rsp_a(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b0;
    @(negedge clock);
    while (a_rsp_valid !== 1'b1) begin
      lat++;
      if (lat > 3000) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic ack_rsp_a();
    a_rsp_ready = 1'b1;
    @(posedge clock);
    #1 a_rsp_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b want 1", a_req_ready); end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got %b want 0", a_rsp_valid); end
    total++; if (a_rsp_data !== 64'd0) begin bad++; $display("FAIL rst_rsp_data got %h want 0", a_rsp_data); end
    total++; if (a_sck !== 1'b0) begin bad++; $display("FAIL rst_sck got %b want 0", a_sck); end
    total++; if (a_ss !== 8'hFF) begin bad++; $display("FAIL rst_ss got %h want ff", a_ss); end
    total++; if (a_mosi !== 1'b1) begin bad++; $display("FAIL rst_mosi got %b want 1", a_mosi); end
    total++; if (b_req_ready !== 1'b1 || b_sck !== 1'b0) begin bad++; $display("FAIL rst_b ready=%b sck=%b want 1/0", b_req_ready, b_sck); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (a_req_ready !== 1'b1 || a_ss !== 8'hFF) begin bad++; $display("FAIL post_rst ready=%b ss=%h want 1/ff", a_req_ready, a_ss); end
  endtask

  task automatic test_loopback();
    int lat; bit to;
    start_a(8, 64'hA5, 8'h01, 1'b1, 64'd0);
    wait_rsp_a(lat, to);
    total++; if (to) begin bad++; $display("FAIL lb_timeout got no rsp_valid want rsp_valid"); end
    total++; if (lat != 35) begin bad++; $display("FAIL lb_latency got %0d want 35", lat); end
    total++; if (a_rsp_data !== 64'hA5) begin bad++; $display("FAIL lb_data got %h want a5", a_rsp_data); end
    total++; if (rises_a != 8) begin bad++; $display("FAIL lb_rises got %0d want 8", rises_a); end
    total++; if (mosi_cap_a[7:0] !== 8'hA5) begin bad++; $display("FAIL lb_mosi got %h want a5", mosi_cap_a[7:0]); end
    total++; if (ss_err_a != 0 || ss_act_a != 34) begin bad++; $display("FAIL lb_ss err=%0d act=%0d want 0/34", ss_err_a, ss_act_a); end
    total++; if (tim_err_a != 0) begin bad++; $display("FAIL lb_sck_timing got %0d want 0", tim_err_a); end
    ack_rsp_a();
  endtask

  task automatic test_slave_byte();
    int lat; bit to;
    start_a(16, 64'hFF00, 8'h02, 1'b0, 64'h003C);
    wait_rsp_a(lat, to);
    total++; if (to || lat != 67) begin bad++; $display("FAIL sb_latency got %0d (to=%0b) want 67", lat, to); end
    total++; if (a_rsp_data[7:0] !== 8'h3C) begin bad++; $display("FAIL sb_byte got %h want 3c", a_rsp_data[7:0]); end
    total++; if (a_rsp_data[63:16] !== 48'd0) begin bad++; $display("FAIL sb_upper got %h want 0", a_rsp_data[63:16]); end
    total++; if (a_rsp_data !== 64'h003C) begin bad++; $display("FAIL sb_data got %h want 3c", a_rsp_data); end
    total++; if (mosi_cap_a[15:0] !== 16'hFF00 || rises_a != 16) begin bad++; $display("FAIL sb_mosi got %h/%0d want ff00/16", mosi_cap_a[15:0], rises_a); end
    ack_rsp_a();
  endtask

  task automatic test_len_edges();
    int lat; bit to; logic [63:0] d;
    d = {$urandom, $urandom};
    start_a(0, d, 8'h01, 1'b1, 64'd0);
    wait_rsp_a(lat, to);
    total++; if (to || lat != 1) begin bad++; $display("FAIL len0_latency got %0d want 1", lat); end
    total++; if (a_rsp_data !== 64'd0) begin bad++; $display("FAIL len0_data got %h want 0", a_rsp_data); end
    total++; if (rises_a != 0 || ss_act_a != 0) begin bad++; $display("FAIL len0_quiet rises=%0d ss_act=%0d want 0/0", rises_a, ss_act_a); end
    ack_rsp_a();
    d = {$urandom, $urandom};
    start_a(70, d, 8'h04, 1'b1, 64'd0);
    wait_rsp_a(lat, to);
    total++; if (rises_a != 64) begin bad++; $display("FAIL len70_rises got %0d want 64", rises_a); end
    total++; if (to || lat != 259) begin bad++; $display("FAIL len70_latency got %0d want 259", lat); end
    total++; if (a_rsp_data !== d) begin bad++; $display("FAIL len70_data got %h want %h", a_rsp_data, d); end
    ack_rsp_a();
  endtask

  task automatic test_backpressure();
    int lat; bit to; int stable_err;
    start_a(8, 64'h5A, 8'h01, 1'b0, 64'h96);
    wait_rsp_a(lat, to);
    total++; if (to || a_rsp_data !== 64'h96) begin bad++; $display("FAIL bp_first got %h want 96", a_rsp_data); end
    a_req_len   = LW'(4);
    a_req_data  = 64'hC;
    a_req_ss    = 8'h10;
    a_req_valid = 1'b1;
    stable_err  = 0;
    repeat (20) begin
      @(negedge clock);
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 64'h96 || a_req_ready !== 1'b0) stable_err++;
    end
    total++; if (stable_err != 0) begin bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", stable_err); end
    clr_mon_a();
    lb_a     = 1'b1;
    exp_ss_a = ~8'h10;
    a_rsp_ready = 1'b1;
    @(posedge clock);
    #1 a_rsp_ready = 1'b0;
    @(negedge clock);
    total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready); end
    total++; if (rises_a != 0) begin bad++; $display("FAIL bp_no_overlap got %0d rises want 0", rises_a); end
    @(posedge clock);
    #1 a_req_valid = 1'b0;
    wait_rsp_a(lat, to);
    total++; if (to || lat != 19) begin bad++; $display("FAIL bp_second_latency got %0d want 19", lat); end
    total++; if (a_rsp_data !== 64'hC || rises_a != 4) begin bad++; $display("FAIL bp_second got %h/%0d want c/4", a_rsp_data, rises_a); end
    ack_rsp_a();
  endtask

  task automatic test_reset_mid();
    int lat; bit to; int n; int spurious;
    start_a(8, 64'hF0, 8'h01, 1'b1, 64'd0);
    n = 0;
    while (!(rises_a == 3 && a_sck === 1'b1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++; if (n >= 200) begin bad++; $display("FAIL mid_reach got no third rise want third rise"); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++; if (a_sck !== 1'b0 || a_ss !== 8'hFF || a_mosi !== 1'b1) begin bad++; $display("FAIL mid_lines sck=%b ss=%h mosi=%b want 0/ff/1", a_sck, a_ss, a_mosi); end
    total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin bad++; $display("FAIL mid_hs valid=%b ready=%b want 0/1", a_rsp_valid, a_req_ready); end
    total++; if (a_state !== ST_IDLE || a_rsp_data !== 64'd0) begin bad++; $display("FAIL mid_state got %0d/%h want idle/0", a_state, a_rsp_data); end
    @(negedge clock);
    reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge clock);
      if (a_rsp_valid !== 1'b0) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL mid_no_rsp got %0d valid cycles want 0", spurious); end
    start_a(12, 64'hABC, 8'h80, 1'b1, 64'd0);
    wait_rsp_a(lat, to);
    total++; if (to || lat != 51) begin bad++; $display("FAIL mid_fresh_latency got %0d want 51", lat); end
    total++; if (a_rsp_data !== 64'hABC || rises_a != 12 || tim_err_a != 0) begin bad++; $display("FAIL mid_fresh got %h/%0d/%0d want abc/12/0", a_rsp_data, rises_a, tim_err_a); end
    ack_rsp_a();
  endtask

  task automatic test_random();
    int lat; bit to; int len, le, exp_act;
    logic [63:0] d, pat, exp_rx;
    logic [7:0] ssel;
    bit lb;
    for (int i = 0; i < 12; i++) begin
      len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * 66 : $urandom_range(1, 64);
      le   = (len > MB) ? MB : len;
      d    = {$urandom, $urandom};
      pat  = {$urandom, $urandom};
      ssel = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      lb   = 1'($urandom_range(0, 1));
      exp_rx  = (lb ? d : pat) & mask_of(le);
      exp_act = (ssel == 8'h00 || le == 0) ? 0 : (2 * le + 1) * 2;
      @(negedge clock);
      start_a(len, d, ssel, lb, pat);
      wait_rsp_a(lat, to);
      total++; if (to || lat != exp_lat(le, 2)) begin bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat(le, 2)); end
      total++; if (a_rsp_data !== exp_rx) begin bad++; $display("FAIL rnd%0d_data got %h want %h", i, a_rsp_data, exp_rx); end
      total++; if (rises_a != le || (mosi_cap_a & mask_of(le)) !== (d & mask_of(le))) begin bad++; $display("FAIL rnd%0d_mosi got %h/%0d want %h/%0d", i, mosi_cap_a & mask_of(le), rises_a, d & mask_of(le), le); end
      total++; if (ss_err_a != 0 || ss_act_a != exp_act || tim_err_a != 0) begin bad++; $display("FAIL rnd%0d_lines ss_err=%0d act=%0d tim=%0d want 0/%0d/0", i, ss_err_a, ss_act_a, tim_err_a, exp_act); end
      ack_rsp_a();
    end
  endtask

  task automatic test_h1();
    int lat;
    @(negedge clock);
    rises_b = 0;
    hi_cnt_b = 0;
    b_req_len   = LW'(1);
    b_req_data  = 64'd1;
    b_req_ss    = 8'h01;
    b_req_valid = 1'b1;
    @(posedge clock);
    #1 b_req_valid = 1'b0;
    lat = 0;
    @(negedge clock);
    while (b_rsp_valid !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clock);
    end
    total++; if (lat != 4) begin bad++; $display("FAIL h1_latency got %0d want 4", lat); end
    total++; if (b_rsp_data !== 64'd1) begin bad++; $display("FAIL h1_data got %h want 1", b_rsp_data); end
    total++; if (rises_b != 1 || hi_cnt_b != 1) begin bad++; $display("FAIL h1_sck rises=%0d high=%0d want 1/1", rises_b, hi_cnt_b); end
    b_rsp_ready = 1'b1;
    @(posedge clock);
    #1 b_rsp_ready = 1'b0;
    @(negedge clock);
    total++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin bad++; $display("FAIL h1_ack valid=%b ready=%b want 0/1", b_rsp_valid, b_req_ready); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_rsp_ready = 1'b0; a_req_len = '0; a_req_data = '0; a_req_ss = '0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0; b_req_len = '0; b_req_data = '0; b_req_ss = '0;
    lb_a = 1'b1; slv_q = '0; exp_ss_a = 8'hFF; sck_prev_a = 1'b0; mosi_rise_a = 1'b1;
    sck_prev_b = 1'b0; rises_b = 0; hi_cnt_b = 0;
    clr_mon_a();
    test_reset();
    test_loopback();
    test_slave_byte();
    test_len_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_h1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
